// File: rtl/rob_dual_commit_if.sv
// Rename / CDB / commit bus bundle for the dual-commit reorder buffer.
interface rob_dual_commit_if #(
    parameter int unsigned WIDTH   = 31,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PAYLOAD = 112,
    parameter int unsigned NCDB    = 2
);
    localparam int unsigned PTR = $clog2(DEPTH);
    localparam int unsigned W   = WIDTH + 1;

    // rename side
    logic                 allocValid;
    logic [PAYLOAD-1:0]   allocPayload;
    logic                 allocReady;
    logic [PTR-1:0]       allocTag;

    // common data bus
    logic [NCDB-1:0]      cdbValid;
    logic [NCDB*PTR-1:0]  cdbTag;
    logic [NCDB*W-1:0]    cdbResult;
    logic [NCDB*W-1:0]    cdbTarget;
    logic [NCDB-1:0]      cdbMispredict;

    // commit side
    logic                 commitStall;
    logic [1:0]           commitValid;
    logic [2*PTR-1:0]     commitTag;
    logic [2*PAYLOAD-1:0] commitPayload;
    logic [2*W-1:0]       commitResult;
    logic [2*W-1:0]       commitTarget;
    logic                 commitMispredict;

    // status
    logic [PTR:0]         count;
    logic                 empty;

    modport master (
        output allocValid, allocPayload, cdbValid, cdbTag, cdbResult, cdbTarget,
               cdbMispredict, commitStall,
        input  allocReady, allocTag, commitValid, commitTag, commitPayload,
               commitResult, commitTarget, commitMispredict, count, empty
    );

    modport slave (
        input  allocValid, allocPayload, cdbValid, cdbTag, cdbResult, cdbTarget,
               cdbMispredict, commitStall,
        output allocReady, allocTag, commitValid, commitTag, commitPayload,
               commitResult, commitTarget, commitMispredict, count, empty
    );
endinterface

// File: rtl/rob_dual_commit.sv
// Reorder buffer: in-order alloc, out-of-order CDB completion, in-order dual retire.
module rob_dual_commit #(
    parameter int unsigned WIDTH   = 31,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PAYLOAD = 112,
    parameter int unsigned NCDB    = 2
) (
    input  logic             clk,
    input  logic             globalResetN,
    rob_dual_commit_if.slave bus
);
    localparam int unsigned PTR = $clog2(DEPTH);
    localparam int unsigned W   = WIDTH + 1;

    logic [PTR-1:0]     head;
    logic [PTR-1:0]     tail;
    logic [PTR:0]       occ;
    logic [DEPTH-1:0]   ready;

    logic [PAYLOAD-1:0] payload_mem [DEPTH];
    logic [W-1:0]       result_mem  [DEPTH];
    logic [W-1:0]       target_mem  [DEPTH];
    logic [DEPTH-1:0]   mis_mem;

    logic [PTR-1:0]     tag_a [NCDB];
    logic [W-1:0]       res_a [NCDB];
    logic [W-1:0]       tgt_a [NCDB];
    logic [NCDB-1:0]    in_win;
    logic [NCDB-1:0]    cdb_wr;

    logic [PTR-1:0]     lt      [2];
    logic [1:0]         hit;
    logic [1:0]         eff_rdy;
    logic [1:0]         eff_mis;
    logic [W-1:0]       eff_res [2];
    logic [W-1:0]       eff_tgt [2];

    logic               ret0;
    logic               ret1;
    logic               flush;
    logic               accept;
    logic [PTR:0]       occ_next;

    assign bus.allocReady = (occ != (PTR+1)'(DEPTH)) && globalResetN;
    assign bus.allocTag   = tail;
    assign bus.count      = occ;
    assign bus.empty      = (occ == '0);

    // Unpack CDB ports, window-qualify them, and let the lowest port win on duplicate tags
    always_comb begin
        for (int p = 0; p < int'(NCDB); p++) begin
            tag_a[p]  = bus.cdbTag[p*PTR +: PTR];
            res_a[p]  = bus.cdbResult[p*W +: W];
            tgt_a[p]  = bus.cdbTarget[p*W +: W];
            in_win[p] = bus.cdbValid[p] && ({1'b0, PTR'(tag_a[p] - head)} < occ);
        end
        for (int p = 0; p < int'(NCDB); p++) begin
            cdb_wr[p] = in_win[p];
            for (int q = 0; q < p; q++) begin
                if (in_win[q] && (tag_a[q] == tag_a[p])) begin
                    cdb_wr[p] = 1'b0;
                end
            end
        end
    end

    // Effective readiness and bypassed data for head and head+1
    always_comb begin
        lt[0] = head;
        lt[1] = head + PTR'(1);
        for (int k = 0; k < 2; k++) begin
            hit[k]     = 1'b0;
            eff_res[k] = result_mem[lt[k]];
            eff_tgt[k] = target_mem[lt[k]];
            eff_mis[k] = mis_mem[lt[k]];
            for (int p = 0; p < int'(NCDB); p++) begin
                if (!hit[k] && bus.cdbValid[p] && (tag_a[p] == lt[k])) begin
                    hit[k]     = 1'b1;
                    eff_res[k] = res_a[p];
                    eff_tgt[k] = tgt_a[p];
                    eff_mis[k] = bus.cdbMispredict[p];
                end
            end
            eff_rdy[k] = ready[lt[k]] | hit[k];
        end
    end

    // Retire decision; a mispredicted entry in either lane stops lane 1
    always_comb begin
        ret0     = (occ != '0) && eff_rdy[0] && !bus.commitStall;
        flush    = ret0 && eff_mis[0];
        ret1     = ret0 && !eff_mis[0] && (occ >= (PTR+1)'(2)) && eff_rdy[1] && !eff_mis[1];
        accept   = bus.allocValid && bus.allocReady;
        occ_next = occ + (PTR+1)'(accept) - (PTR+1)'(ret0) - (PTR+1)'(ret1);
    end

    // Pointers, occupancy and ready bits
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            ready <= '0;
        end else if (flush) begin
            head  <= head + PTR'(1);
            tail  <= head + PTR'(1);
            occ   <= '0;
            ready <= '0;
        end else begin
            head <= head + PTR'(ret0) + PTR'(ret1);
            occ  <= occ_next;
            if (accept) begin
                tail <= tail + PTR'(1);
            end
            for (int p = 0; p < int'(NCDB); p++) begin
                if (cdb_wr[p]) begin
                    ready[tag_a[p]] <= 1'b1;
                end
            end
            if (accept) begin
                ready[tail] <= 1'b0;
            end
        end
    end

    // Entry storage; nothing is recorded while reset is asserted
    always_ff @(posedge clk) begin
        if (globalResetN) begin
            for (int p = 0; p < int'(NCDB); p++) begin
                if (cdb_wr[p]) begin
                    result_mem[tag_a[p]] <= res_a[p];
                    target_mem[tag_a[p]] <= tgt_a[p];
                    mis_mem[tag_a[p]]    <= bus.cdbMispredict[p];
                end
            end
            if (accept) begin
                payload_mem[tail] <= bus.allocPayload;
            end
        end
    end

    // Registered commit bus; idle lanes keep their previous data
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            bus.commitValid      <= '0;
            bus.commitMispredict <= 1'b0;
            bus.commitTag        <= '0;
            bus.commitPayload    <= '0;
            bus.commitResult     <= '0;
            bus.commitTarget     <= '0;
        end else begin
            bus.commitValid      <= {ret1, ret0};
            bus.commitMispredict <= flush;
            if (ret0) begin
                bus.commitTag[0 +: PTR]         <= lt[0];
                bus.commitPayload[0 +: PAYLOAD] <= payload_mem[lt[0]];
                bus.commitResult[0 +: W]        <= eff_res[0];
                bus.commitTarget[0 +: W]        <= eff_tgt[0];
            end
            if (ret1) begin
                bus.commitTag[PTR +: PTR]             <= lt[1];
                bus.commitPayload[PAYLOAD +: PAYLOAD] <= payload_mem[lt[1]];
                bus.commitResult[W +: W]              <= eff_res[1];
                bus.commitTarget[W +: W]              <= eff_tgt[1];
            end
        end
    end
endmodule

// File: tb/tb_rob_dual_commit.sv
// Randomized + directed bench for rob_dual_commit against a queue-based model.
module tb_rob_dual_commit;
    localparam int unsigned WIDTH   = 31;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PAYLOAD = 112;
    localparam int unsigned NCDB    = 2;
    localparam int unsigned PTR     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rob_dual_commit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PAYLOAD(PAYLOAD), .NCDB(NCDB)) bus ();

    rob_dual_commit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PAYLOAD(PAYLOAD), .NCDB(NCDB)) dut (
        .clk          (clk),
        .globalResetN (rst_n),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int                 tag;
        logic [PAYLOAD-1:0] pl;
        bit                 done;
        logic [31:0]        res;
        logic [31:0]        tgt;
        bit                 mis;
    } ent_t;

    ent_t               q[$];
    int                 m_tail;
    logic [1:0]         m_cv;
    logic               m_cmis;
    logic [PTR-1:0]     m_ctag [2];
    logic [PAYLOAD-1:0] m_cpl  [2];
    logic [31:0]        m_cres [2];
    logic [31:0]        m_ctgt [2];

    int   sz0, t;
    bit   acc, dup, fl;
    int   seen[$];
    ent_t e0, e1, en;

    task automatic set_lane(input int l, input ent_t e);
        m_ctag[l] = PTR'(e.tag);
        m_cpl[l]  = e.pl;
        m_cres[l] = e.res;
        m_ctgt[l] = e.tgt;
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            q.delete();
            m_tail = 0;
            m_cv   = '0;
            m_cmis = 1'b0;
            for (int l = 0; l < 2; l++) begin
                m_ctag[l] = '0; m_cpl[l] = '0; m_cres[l] = '0; m_ctgt[l] = '0;
            end
        end else begin
            sz0 = q.size();
            acc = bus.allocValid && (sz0 != DEPTH);
            seen.delete();
            // completions: only entries currently in the queue can be written
            for (int p = 0; p < NCDB; p++) begin
                if (bus.cdbValid[p]) begin
                    t = int'(bus.cdbTag[p*PTR +: PTR]);
                    dup = 1'b0;
                    foreach (seen[s]) if (seen[s] == t) dup = 1'b1;
                    seen.push_back(t);
                    if (!dup) begin
                        foreach (q[k]) begin
                            if (q[k].tag == t) begin
                                q[k].done = 1'b1;
                                q[k].res  = bus.cdbResult[p*32 +: 32];
                                q[k].tgt  = bus.cdbTarget[p*32 +: 32];
                                q[k].mis  = bus.cdbMispredict[p];
                            end
                        end
                    end
                end
            end
            m_cv = '0; m_cmis = 1'b0; fl = 1'b0;
            if (!bus.commitStall && q.size() > 0 && q[0].done) begin
                e0 = q.pop_front();
                set_lane(0, e0);
                m_cv[0] = 1'b1;
                if (e0.mis) begin
                    m_cmis = 1'b1;
                    fl     = 1'b1;
                    q.delete();
                    m_tail = (e0.tag + 1) % DEPTH;
                end else if (q.size() > 0 && q[0].done && !q[0].mis) begin
                    e1 = q.pop_front();
                    set_lane(1, e1);
                    m_cv[1] = 1'b1;
                end
            end
            if (acc && !fl) begin
                en.tag = m_tail; en.pl = bus.allocPayload; en.done = 1'b0;
                en.res = '0; en.tgt = '0; en.mis = 1'b0;
                q.push_back(en);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("commitValid", 256'(bus.commitValid), 256'(m_cv));
            chk("commitMispredict", 256'(bus.commitMispredict), 256'(m_cmis));
            chk("commitTag", 256'(bus.commitTag), 256'({m_ctag[1], m_ctag[0]}));
            chk("commitPayload", 256'(bus.commitPayload), 256'({m_cpl[1], m_cpl[0]}));
            chk("commitResult", 256'(bus.commitResult), 256'({m_cres[1], m_cres[0]}));
            chk("commitTarget", 256'(bus.commitTarget), 256'({m_ctgt[1], m_ctgt[0]}));
            chk("count", 256'(bus.count), 256'(q.size()));
            chk("empty", 256'(bus.empty), 256'(q.size() == 0));
            chk("allocReady", 256'(bus.allocReady), 256'((q.size() != DEPTH) && rst_n));
            chk("allocTag", 256'(bus.allocTag), 256'(m_tail));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [PAYLOAD-1:0] rnd_pl();
        logic [127:0] x;
        x = {$urandom, $urandom, $urandom, $urandom};
        return PAYLOAD'(x);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cdb();
        bus.cdbValid      = '0;
        bus.cdbMispredict = '0;
    endtask

    task automatic idle();
        bus.allocValid   = 1'b0;
        bus.allocPayload = '0;
        bus.commitStall  = 1'b0;
        bus.cdbTag       = '0;
        bus.cdbResult    = '0;
        bus.cdbTarget    = '0;
        clr_cdb();
    endtask

    task automatic cdb(input int p, input int tag, input logic [31:0] res, input bit mis);
        bus.cdbValid[p]           = 1'b1;
        bus.cdbTag[p*PTR +: PTR]  = PTR'(tag);
        bus.cdbResult[p*32 +: 32] = res;
        bus.cdbTarget[p*32 +: 32] = ~res;
        bus.cdbMispredict[p]      = mis;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.allocValid   = 1'b1;
            bus.allocPayload = rnd_pl();
            cyc();
        end
        bus.allocValid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        chk("rst_count", 256'(bus.count), 256'(0));
        chk("rst_valid", 256'(bus.commitValid), 256'(0));
        chk("rst_allocReady", 256'(bus.allocReady), 256'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_allocReady", 256'(bus.allocReady), 256'(1));

        // fill to DEPTH with no completions
        for (int i = 0; i < 8; i++) begin
            bus.allocValid   = 1'b1;
            bus.allocPayload = rnd_pl();
            chk("fill_allocTag", 256'(bus.allocTag), 256'(i));
            cyc();
        end
        bus.allocValid = 1'b0;
        chk("full_count", 256'(bus.count), 256'(8));
        chk("full_allocReady", 256'(bus.allocReady), 256'(0));
        chk("full_empty", 256'(bus.empty), 256'(0));
        cyc();
        chk("full_no_commit", 256'(bus.commitValid), 256'(0));

        // out-of-order completion
        do_reset();
        alloc_n(4);
        cdb(0, 2, 32'h2222_2222, 1'b0); cyc(); clr_cdb();
        chk("ooo_wait2", 256'(bus.commitValid), 256'(0));
        cdb(0, 1, 32'h1111_1111, 1'b0); cyc(); clr_cdb();
        chk("ooo_wait1", 256'(bus.commitValid), 256'(0));
        cdb(0, 0, 32'h0000_0F0F, 1'b0); cyc(); clr_cdb();
        chk("ooo_dual_valid", 256'(bus.commitValid), 256'(3));
        chk("ooo_dual_tags", 256'(bus.commitTag), 256'({3'd1, 3'd0}));
        chk("ooo_dual_res", 256'(bus.commitResult), 256'({32'h1111_1111, 32'h0000_0F0F}));
        cyc();
        chk("ooo_third_valid", 256'(bus.commitValid), 256'(1));
        chk("ooo_third_tag", 256'(bus.commitTag[2:0]), 256'(2));

        // two ports completing the two oldest in one cycle
        do_reset();
        alloc_n(2);
        cdb(0, 0, 32'hA5A5_0000, 1'b0);
        cdb(1, 1, 32'h0000_5A5A, 1'b0);
        cyc(); clr_cdb();
        chk("dual_valid", 256'(bus.commitValid), 256'(3));
        chk("dual_res", 256'(bus.commitResult), 256'({32'h0000_5A5A, 32'hA5A5_0000}));

        // mispredict flush
        do_reset();
        alloc_n(5);
        cdb(0, 0, 32'h0, 1'b0); cdb(1, 1, 32'h1, 1'b1); cyc(); clr_cdb();
        chk("mis_lane0_only", 256'(bus.commitValid), 256'(1));
        chk("mis_not_yet", 256'(bus.commitMispredict), 256'(0));
        cdb(0, 2, 32'h2, 1'b0); cdb(1, 3, 32'h3, 1'b0); cyc(); clr_cdb();
        chk("mis_valid", 256'(bus.commitValid), 256'(1));
        chk("mis_flag", 256'(bus.commitMispredict), 256'(1));
        chk("mis_tag", 256'(bus.commitTag[2:0]), 256'(1));
        chk("mis_count", 256'(bus.count), 256'(0));
        chk("mis_allocTag", 256'(bus.allocTag), 256'(2));
        cdb(0, 4, 32'h4, 1'b0); cyc(); clr_cdb();
        chk("mis_squashed", 256'(bus.commitValid), 256'(0));
        alloc_n(1);
        chk("mis_realloc_count", 256'(bus.count), 256'(1));
        cyc(); cyc();

        // full buffer, wrap, out-of-window write
        do_reset();
        alloc_n(6);
        cdb(0, 0, 32'h10, 1'b0); cdb(1, 1, 32'h11, 1'b0); cyc();
        cdb(0, 2, 32'h12, 1'b0); cdb(1, 3, 32'h13, 1'b0); cyc();
        cdb(0, 4, 32'h14, 1'b0); cdb(1, 5, 32'h15, 1'b0); cyc(); clr_cdb();
        cyc(); cyc();
        chk("wrap_drained", 256'(bus.count), 256'(0));
        alloc_n(8);
        chk("wrap_full", 256'(bus.count), 256'(8));
        chk("wrap_tail", 256'(bus.allocTag), 256'(6));
        cdb(0, 6, 32'h16, 1'b0); bus.allocValid = 1'b1; bus.allocPayload = rnd_pl(); cyc();
        chk("wrap_full_no_accept", 256'(bus.count), 256'(7));
        cdb(0, 7, 32'h17, 1'b0); bus.allocPayload = rnd_pl(); cyc();
        bus.allocValid = 1'b0; clr_cdb();
        chk("wrap_ret_alloc_count", 256'(bus.count), 256'(7));
        chk("wrap_allocTag", 256'(bus.allocTag), 256'(7));
        cdb(0, 7, 32'hDEAD_BEEF, 1'b0); cyc(); clr_cdb();
        chk("wrap_out_of_window", 256'(bus.commitValid), 256'(0));
        cdb(0, 0, 32'h20, 1'b0); cyc(); clr_cdb();
        cyc();

        // commit stall
        do_reset();
        alloc_n(1);
        bus.commitStall = 1'b1;
        cdb(0, 0, 32'h5757_5757, 1'b0); cyc(); clr_cdb();
        chk("stall_1", 256'(bus.commitValid), 256'(0));
        cyc();
        chk("stall_2", 256'(bus.commitValid), 256'(0));
        cyc();
        chk("stall_3", 256'(bus.commitValid), 256'(0));
        bus.commitStall = 1'b0;
        cyc();
        chk("stall_release", 256'(bus.commitValid), 256'(1));
        chk("stall_release_res", 256'(bus.commitResult[31:0]), 256'(32'h5757_5757));

        // mid-run reset
        alloc_n(3);
        cdb(0, 1, 32'h1, 1'b0); cdb(1, 2, 32'h2, 1'b0);
        rst_n = 1'b0; cyc(); clr_cdb();
        chk("midrst_count", 256'(bus.count), 256'(0));
        chk("midrst_valid", 256'(bus.commitValid), 256'(0));
        chk("midrst_res", 256'(bus.commitResult), 256'(0));
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n            = ($urandom_range(0, 299) != 0);
            bus.allocValid   = ($urandom_range(0, 9) < 7);
            bus.allocPayload = rnd_pl();
            bus.commitStall  = ($urandom_range(0, 7) == 0);
            clr_cdb();
            for (int p = 0; p < NCDB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    cdb(p, int'($urandom_range(0, DEPTH - 1)), $urandom,
                        ($urandom_range(0, 15) == 0));
                end
            end
            cyc();
        end
        idle();
        rst_n = 1'b1;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
